inst_fetch: RTL and testbench

Instruction-fetch stage of the Gumnut core. It sits directly upstream of the control unit and owns the program counter, the instruction-bus master (Wishbone-style cyc/stb/ack), the instruction register and the op/func field extraction that drives the control unit's decode. It also applies PC updates commanded by the control unit (branch, jump, subroutine call/return, interrupt entry/exit) and maintains the return-address stack.

---
 rtl/inst_fetch_pkg.sv | 53 +++++
 rtl/inst_fetch_if.sv | 16 +
 rtl/inst_fetch_ret_stack.sv | 55 +++++
 rtl/inst_fetch.sv | 133 +++++++++++++
 tb/tb_inst_fetch.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared Gumnut definitions: PC operation codes, opcode prefixes and the IR field decoder.
package gumnut_pkg;
   localparam int               PC_W_DEF        = 12;
   localparam int               IW_DEF          = 18;
   localparam int               STACK_DEPTH_DEF = 8;
   localparam logic [11:0]      INT_VEC_DEF     = 12'h001;

   typedef enum logic [3:0] {
      PC_HOLD   = 4'd0,
      PC_BRANCH = 4'd1,
      PC_JMP    = 4'd2,
      PC_JSB    = 4'd3,
      PC_RET    = 4'd4,
      PC_INT    = 4'd5,
      PC_RETI   = 4'd6
   } pc_oper_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } bus_state_e;

   localparam logic [6:0] OP_ALUI  = 7'b0000000;
   localparam logic [6:0] OP_MEM   = 7'b0000010;
   localparam logic [6:0] OP_SHIFT = 7'b0000110;
   localparam logic [6:0] OP_ALUR  = 7'b0001110;
   localparam logic [6:0] OP_JMP   = 7'b0011110;
   localparam logic [6:0] OP_BR    = 7'b0111110;
   localparam logic [6:0] OP_MISC  = 7'b1111110;
   localparam logic [6:0] OP_NONE  = 7'b1111111;

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] func;
   } decode_t;

   // Opcode prefixes are a run of leading ones; func comes from a different field per class.
   function automatic decode_t decode_ir(input logic [17:0] ir);
      decode_t d;
      d = '{op: OP_NONE, func: 3'b000};
      casez (ir[17:11])
         7'b0??????: d = '{op: OP_ALUI,  func: ir[16:14]};
         7'b10?????: d = '{op: OP_MEM,   func: {1'b0, ir[15:14]}};
         7'b110????: d = '{op: OP_SHIFT, func: {1'b0, ir[1:0]}};
         7'b1110???: d = '{op: OP_ALUR,  func: ir[2:0]};
         7'b11110??: d = '{op: OP_JMP,   func: {2'b00, ir[12]}};
         7'b111110?: d = '{op: OP_BR,    func: {1'b0, ir[11:10]}};
         7'b1111110: d = '{op: OP_MISC,  func: ir[10:8]};
         default:    d = '{op: OP_NONE,  func: 3'b000};
      endcase
      return d;
   endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-bus (Wishbone-style cyc/stb/ack) between the fetch stage and instruction memory.
interface inst_fetch_if #(
   parameter int PC_W = 12,
   parameter int IW   = 18
);
   logic            inst_cyc;
   logic            inst_stb;
   logic [PC_W-1:0] inst_adr;
   logic [IW-1:0]   inst_dat;
   logic            inst_ack;

   modport master (output inst_cyc, output inst_stb, output inst_adr,
                   input  inst_dat, input  inst_ack);
   modport slave  (input  inst_cyc, input  inst_stb, input  inst_adr,
                   output inst_dat, output inst_ack);
endinterface

// File: rtl/inst_fetch_ret_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, an empty pop flags an error.
module ret_stack #(
   parameter int DEPTH = 8,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_top,
   output logic         o_empty,
   output logic         o_err
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_ptr;
   logic [AW:0]   r_cnt;
   logic [AW-1:0] w_top_idx;

   assign w_top_idx = r_ptr - PTR_ONE;
   assign o_top     = r_mem[w_top_idx];
   assign o_empty   = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_ptr] <= i_din;
   end

   // r_ptr is the next write slot; a full push just keeps rotating over the oldest entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
         r_cnt <= '0;
         o_err <= 1'b0;
      end else begin
         o_err <= 1'b0;
         if (i_push) begin
            r_ptr <= r_ptr + PTR_ONE;
            if (r_cnt == CNT_FULL) o_err <= 1'b1;
            else                   r_cnt <= r_cnt + CNT_ONE;
         end else if (i_pop) begin
            if (o_empty) begin
               o_err <= 1'b1;
            end else begin
               r_ptr <= w_top_idx;
               r_cnt <= r_cnt - CNT_ONE;
            end
         end
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// Gumnut instruction-fetch stage: PC, instruction-bus master, IR with op/func decode, PC updates.
// state  | meaning
// S_IDLE | no bus cycle; waiting for fetch_i
// S_REQ  | cyc/stb asserted, holding the request until inst_ack
module inst_fetch
   import gumnut_pkg::*;
#(
   parameter int              PC_W        = PC_W_DEF,
   parameter int              IW          = IW_DEF,
   parameter int              STACK_DEPTH = STACK_DEPTH_DEF,
   parameter logic [PC_W-1:0] INT_VEC     = INT_VEC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_i,
   inst_fetch_if.master    bus,
   output logic            inst_ack_o,
   output logic [IW-1:0]   ir_o,
   output logic [6:0]      op_o,
   output logic [2:0]      func_o,
   input  logic            pc_upd_i,
   input  logic [3:0]      pc_oper_i,
   input  logic            taken_i,
   output logic [PC_W-1:0] pc_o,
   output logic            stack_err_o
);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   bus_state_e      r_state;
   logic            r_cyc;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_int_pc;
   logic [IW-1:0]   r_ir;

   logic            w_ack;
   logic            w_push;
   logic            w_pop;
   logic            w_int_save;
   logic            w_stk_empty;
   logic [PC_W-1:0] w_stk_top;
   logic [PC_W-1:0] w_br_disp;
   logic [PC_W-1:0] w_pc_nxt;
   decode_t         w_dec;

   assign w_ack        = bus.inst_ack & r_cyc;
   assign inst_ack_o   = w_ack;
   assign bus.inst_cyc = r_cyc;
   assign bus.inst_stb = r_cyc;
   assign bus.inst_adr = r_pc;
   assign pc_o         = r_pc;
   assign ir_o         = r_ir;
   assign w_dec        = decode_ir(r_ir);
   assign op_o         = w_dec.op;
   assign func_o       = w_dec.func;
   assign w_br_disp    = {{(PC_W-8){r_ir[7]}}, r_ir[7:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cyc   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (fetch_i) begin
               r_state <= S_REQ;
               r_cyc   <= 1'b1;
            end
            S_REQ: if (bus.inst_ack) begin
               r_state <= S_IDLE;
               r_cyc   <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_cyc   <= 1'b0;
            end
         endcase
      end
   end

   // A control-unit update overrides the fetch increment, even for hold.
   always_comb begin
      w_pc_nxt   = w_ack ? r_pc + PC_ONE : r_pc;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_int_save = 1'b0;
      if (pc_upd_i) begin
         w_pc_nxt = r_pc;
         case (pc_oper_e'(pc_oper_i))
            PC_BRANCH: if (taken_i) w_pc_nxt = r_pc + w_br_disp;
            PC_JMP:    w_pc_nxt = r_ir[PC_W-1:0];
            PC_JSB: begin
               w_push   = 1'b1;
               w_pc_nxt = r_ir[PC_W-1:0];
            end
            PC_RET: begin
               w_pop    = 1'b1;
               w_pc_nxt = w_stk_empty ? '0 : w_stk_top;
            end
            PC_INT: begin
               w_int_save = 1'b1;
               w_pc_nxt   = INT_VEC;
            end
            PC_RETI:   w_pc_nxt = r_int_pc;
            default:   w_pc_nxt = r_pc;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= '0;
         r_ir     <= '0;
         r_int_pc <= '0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_ack)      r_ir     <= bus.inst_dat;
         if (w_int_save) r_int_pc <= r_pc;
      end
   end

   ret_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (PC_W)
   ) u_ret_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (r_pc),
      .o_top   (w_stk_top),
      .o_empty (w_stk_empty),
      .o_err   (stack_err_o)
   );
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random fetch/PC-update traffic vs a queue-based model.
module tb_inst_fetch;
   import gumnut_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_i = 1'b0;
   logic        pc_upd_i = 1'b0;
   logic [3:0]  pc_oper_i = 4'd0;
   logic        taken_i = 1'b0;
   logic        inst_ack_o;
   logic [17:0] ir_o;
   logic [6:0]  op_o;
   logic [2:0]  func_o;
   logic [11:0] pc_o;
   logic        stack_err_o;

   int checks = 0;
   int failures = 0;

   inst_fetch_if #(.PC_W(12), .IW(18)) bus ();

   inst_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_i     (fetch_i),
      .bus         (bus),
      .inst_ack_o  (inst_ack_o),
      .ir_o        (ir_o),
      .op_o        (op_o),
      .func_o      (func_o),
      .pc_upd_i    (pc_upd_i),
      .pc_oper_i   (pc_oper_i),
      .taken_i     (taken_i),
      .pc_o        (pc_o),
      .stack_err_o (stack_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [11:0] m_pc;
   logic [11:0] m_int_pc;
   logic [17:0] m_ir;
   logic [11:0] m_stk[$];

   function automatic void model_reset();
      m_pc = '0;
      m_int_pc = '0;
      m_ir = '0;
      m_stk.delete();
   endfunction

   // op = leading-ones count n of IR[17:11] mapped to a run of n ones shifted left by one.
   function automatic logic [9:0] model_decode(input logic [17:0] ir);
      int n;
      logic [6:0] op;
      logic [2:0] f;
      n = 0;
      while (n < 7 && ir[17-n]) n++;
      op = (n == 7) ? 7'h7F : 7'(((1 << n) - 1) << 1);
      case (n)
         0: f = ir[16:14];
         1: f = {1'b0, ir[15:14]};
         2: f = {1'b0, ir[1:0]};
         3: f = ir[2:0];
         4: f = {2'b00, ir[12]};
         5: f = {1'b0, ir[11:10]};
         6: f = ir[10:8];
         default: f = 3'b000;
      endcase
      return {op, f};
   endfunction

   function automatic bit model_op(input int oper, input bit taken);
      bit err;
      err = 1'b0;
      case (oper)
         1: if (taken) m_pc = m_pc + {{4{m_ir[7]}}, m_ir[7:0]};
         2: m_pc = m_ir[11:0];
         3: begin
            m_stk.push_back(m_pc);
            if (m_stk.size() > 8) begin
               void'(m_stk.pop_front());
               err = 1'b1;
            end
            m_pc = m_ir[11:0];
         end
         4: begin
            if (m_stk.size() == 0) begin
               m_pc = '0;
               err = 1'b1;
            end else begin
               m_pc = m_stk.pop_back();
            end
         end
         5: begin
            m_int_pc = m_pc;
            m_pc = 12'h001;
         end
         6: m_pc = m_int_pc;
         default: ;
      endcase
      return err;
   endfunction

   // ---------------- stimulus drivers ----------------
   task automatic do_fetch(input logic [17:0] dat, input int waits);
      int n;
      fetch_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.inst_cyc !== 1'b1 && n < 8);
      checks++;
      if (bus.inst_cyc !== 1'b1 || bus.inst_stb !== 1'b1 || n != 1) begin
         failures++;
         $display("FAIL fetch_req cyc=%b stb=%b after %0d cycles, required cyc=1 stb=1 after 1", bus.inst_cyc, bus.inst_stb, n);
      end
      fetch_i = 1'b0;
      checks++;
      if (bus.inst_adr !== m_pc) begin
         failures++;
         $display("FAIL fetch_adr got=%h exp=%h", bus.inst_adr, m_pc);
      end
      for (int i = 0; i < waits; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (bus.inst_cyc !== 1'b1) begin
         failures++;
         $display("FAIL fetch_hold cyc=%b exp=1 after %0d wait states", bus.inst_cyc, waits);
      end
      bus.inst_dat = dat;
      bus.inst_ack = 1'b1;
      #1;
      checks++;
      if (inst_ack_o !== 1'b1) begin
         failures++;
         $display("FAIL fetch_ack_o got=%b exp=1", inst_ack_o);
      end
      @(posedge clk); #1;
      bus.inst_ack = 1'b0;
      m_ir = dat;
      m_pc = m_pc + 12'd1;
      checks++;
      if (ir_o !== m_ir || {op_o, func_o} !== model_decode(m_ir)) begin
         failures++;
         $display("FAIL fetch_ir ir=%h op=%b func=%b exp ir=%h op/func=%b", ir_o, op_o, func_o, m_ir, model_decode(m_ir));
      end
      checks++;
      if (pc_o !== m_pc || bus.inst_cyc !== 1'b0) begin
         failures++;
         $display("FAIL fetch_pc pc=%h cyc=%b exp pc=%h cyc=0", pc_o, bus.inst_cyc, m_pc);
      end
   endtask

   task automatic do_upd(input int oper, input bit taken);
      bit exp_err;
      pc_upd_i = 1'b1;
      pc_oper_i = 4'(oper);
      taken_i = taken;
      @(posedge clk); #1;
      pc_upd_i = 1'b0;
      taken_i = 1'b0;
      exp_err = model_op(oper, taken);
      checks++;
      if (pc_o !== m_pc || stack_err_o !== exp_err) begin
         failures++;
         $display("FAIL upd_oper%0d pc=%h err=%b exp pc=%h err=%b", oper, pc_o, stack_err_o, m_pc, exp_err);
      end
      @(posedge clk); #1;
      checks++;
      if (stack_err_o !== 1'b0 || pc_o !== m_pc) begin
         failures++;
         $display("FAIL upd_after_oper%0d err=%b pc=%h exp err=0 pc=%h", oper, stack_err_o, pc_o, m_pc);
      end
   endtask

   task automatic set_pc_ir(input logic [11:0] pc, input logic [11:0] low12);
      do_fetch({6'($urandom), 12'(pc - 12'd1)}, $urandom_range(2, 0));
      do_upd(2, 1'b0);
      do_fetch({6'($urandom), low12}, $urandom_range(2, 0));
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      bus.inst_ack = 1'b0;
      bus.inst_dat = '0;
      model_reset();
      #22;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (pc_o !== 12'h000 || ir_o !== 18'h0 || op_o !== 7'b0 || func_o !== 3'b0) begin
         failures++;
         $display("FAIL reset_regs pc=%h ir=%h op=%b func=%b exp all zero", pc_o, ir_o, op_o, func_o);
      end
      checks++;
      if (bus.inst_cyc !== 1'b0 || bus.inst_stb !== 1'b0 || stack_err_o !== 1'b0 || inst_ack_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_outs cyc=%b stb=%b err=%b ack_o=%b exp 0", bus.inst_cyc, bus.inst_stb, stack_err_o, inst_ack_o);
      end
   endtask

   task automatic test_first_fetch();
      do_fetch(18'h2C005, 2);
      checks++;
      if (ir_o !== 18'h2C005 || op_o !== 7'b0000010 || func_o !== 3'b011 || pc_o !== 12'h001) begin
         failures++;
         $display("FAIL first_fetch ir=%h op=%b func=%b pc=%h exp 2c005 0000010 011 001", ir_o, op_o, func_o, pc_o);
      end
   endtask

   task automatic test_branch();
      set_pc_ir(12'h010, 12'h0FC);
      do_upd(1, 1'b0);
      checks++;
      if (pc_o !== 12'h010) begin
         failures++;
         $display("FAIL branch_not_taken pc=%h exp=010", pc_o);
      end
      do_upd(1, 1'b1);
      checks++;
      if (pc_o !== 12'h00C) begin
         failures++;
         $display("FAIL branch_taken pc=%h exp=00c", pc_o);
      end
   endtask

   task automatic test_jsb_ret();
      set_pc_ir(12'h021, 12'h200);
      do_upd(3, 1'b0);
      checks++;
      if (pc_o !== 12'h200) begin
         failures++;
         $display("FAIL jsb_target pc=%h exp=200", pc_o);
      end
      do_upd(4, 1'b0);
      checks++;
      if (pc_o !== 12'h021) begin
         failures++;
         $display("FAIL ret_addr pc=%h exp=021", pc_o);
      end
   endtask

   task automatic test_stack_overflow();
      logic [11:0] ra [9];
      for (int i = 0; i < 9; i++) begin
         do_fetch({6'($urandom), 12'(12'h100 + 12'(i * 16))}, 0);
         ra[i] = m_pc;
         do_upd(3, 1'b0);
      end
      // Last push wiped the 1st call's entry; the 8th ret reaches the 2nd call's, the 9th underflows.
      for (int i = 0; i < 9; i++) begin
         pc_upd_i = 1'b1;
         pc_oper_i = 4'd4;
         @(posedge clk); #1;
         pc_upd_i = 1'b0;
         void'(model_op(4, 1'b0));
         checks++;
         if (i < 8) begin
            if (pc_o !== ra[8-i] || stack_err_o !== 1'b0) begin
               failures++;
               $display("FAIL nested_ret%0d pc=%h err=%b exp pc=%h err=0", i + 1, pc_o, stack_err_o, ra[8-i]);
            end
         end else begin
            if (pc_o !== 12'h000 || stack_err_o !== 1'b1) begin
               failures++;
               $display("FAIL nested_ret9 pc=%h err=%b exp pc=000 err=1", pc_o, stack_err_o);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow_pulse();
      // Refill to full, then one more push must pulse the error only on that push.
      for (int i = 0; i < 9; i++) begin
         do_fetch({6'($urandom), 12'($urandom)}, 0);
         pc_upd_i = 1'b1;
         pc_oper_i = 4'd3;
         @(posedge clk); #1;
         pc_upd_i = 1'b0;
         checks++;
         if (stack_err_o !== (i == 8) || model_op(3, 1'b0) !== (i == 8)) begin
            failures++;
            $display("FAIL push%0d_err err=%b exp=%b", i + 1, stack_err_o, (i == 8));
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) do_upd(4, 1'b0);
   endtask

   task automatic test_underflow();
      do_fetch({6'($urandom), 12'($urandom)}, 1);
      do_upd(4, 1'b0);
      checks++;
      if (pc_o !== 12'h000) begin
         failures++;
         $display("FAIL underflow_pc pc=%h exp=000", pc_o);
      end
   endtask

   task automatic test_interrupt();
      set_pc_ir(12'h345, 12'($urandom));
      do_upd(5, 1'b0);
      checks++;
      if (pc_o !== 12'h001) begin
         failures++;
         $display("FAIL int_vector pc=%h exp=001", pc_o);
      end
      do_upd(6, 1'b0);
      checks++;
      if (pc_o !== 12'h345) begin
         failures++;
         $display("FAIL reti_addr pc=%h exp=345", pc_o);
      end
      do_upd(5, 1'b0);
      do_fetch({6'($urandom), 12'($urandom)}, 0);
      do_upd(5, 1'b0);
      do_upd(6, 1'b0);
      checks++;
      if (pc_o !== 12'h002) begin
         failures++;
         $display("FAIL nested_int_reti pc=%h exp=002", pc_o);
      end
   endtask

   task automatic test_upd_with_ack();
      logic [17:0] dat;
      int n;
      set_pc_ir(12'h0A0, 12'h7B3);
      dat = 18'($urandom);
      fetch_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.inst_cyc !== 1'b1 && n < 8);
      fetch_i = 1'b0;
      bus.inst_dat = dat;
      bus.inst_ack = 1'b1;
      pc_upd_i = 1'b1;
      pc_oper_i = 4'd2;
      @(posedge clk); #1;
      bus.inst_ack = 1'b0;
      pc_upd_i = 1'b0;
      void'(model_op(2, 1'b0));
      m_ir = dat;
      checks++;
      if (pc_o !== 12'h7B3 || ir_o !== dat) begin
         failures++;
         $display("FAIL upd_with_ack pc=%h ir=%h exp pc=7b3 ir=%h", pc_o, ir_o, dat);
      end
   endtask

   task automatic test_reset_mid_req();
      int n;
      do_fetch({6'($urandom), 12'h3FF}, 0);
      fetch_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.inst_cyc !== 1'b1 && n < 8);
      fetch_i = 1'b0;
      bus.inst_dat = 18'h3FFFF;
      bus.inst_ack = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.inst_cyc !== 1'b0 || bus.inst_stb !== 1'b0 || inst_ack_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_req cyc=%b stb=%b ack_o=%b exp 0 0 0", bus.inst_cyc, bus.inst_stb, inst_ack_o);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.inst_ack = 1'b0;
      model_reset();
      @(posedge clk); #1;
      checks++;
      if (ir_o !== 18'h0 || pc_o !== 12'h000 || bus.inst_cyc !== 1'b0) begin
         failures++;
         $display("FAIL rst_release ir=%h pc=%h cyc=%b exp 0 0 0", ir_o, pc_o, bus.inst_cyc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(1, 0) == 0)
            do_fetch(18'($urandom), $urandom_range(3, 0));
         else
            do_upd($urandom_range(15, 0), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_branch();
      test_jsb_ret();
      test_stack_overflow();
      test_overflow_pulse();
      test_underflow();
      test_interrupt();
      test_upd_with_ack();
      test_random();
      test_reset_mid_req();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
